// File: rtl/izh_spike_analyzer_if.sv
// Bundle carrying the neuron sample stream into the analyzer and its registered
// spike statistics back out to the readout/debug mux.
interface izh_spike_analyzer_if;
  logic        en;
  logic        spike;
  logic [7:0]  v_in;
  logic [15:0] isi;
  logic        isi_valid;
  logic [7:0]  rate;
  logic        rate_valid;
  logic [7:0]  v_peak;
  logic        burst;

  modport master (
    output en, spike, v_in,
    input  isi, isi_valid, rate, rate_valid, v_peak, burst
  );

  modport slave (
    input  en, spike, v_in,
    output isi, isi_valid, rate, rate_valid, v_peak, burst
  );
endinterface

// File: rtl/izh_spike_analyzer.sv
// Spike statistics for the Izhikevich core: inter-spike interval, burst detect,
// spike rate and peak membrane sample per fixed window.
module izh_spike_analyzer #(
  parameter int WINDOW    = 4096,
  parameter int BURST_ISI = 64,
  parameter int BURST_MIN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  izh_spike_analyzer_if.slave  bus
);

  localparam int          WIN_W   = $clog2(WINDOW);
  localparam logic [15:0] ISI_LIM = 16'(BURST_ISI);
  localparam logic [3:0]  RUN_LIM = 4'(BURST_MIN - 1);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t           state;
  logic             spike_d;
  logic [15:0]      isi_cnt;
  logic [3:0]       run;
  logic [WIN_W-1:0] win_cnt;
  logic [7:0]       acc;
  logic [7:0]       peak_run;

  logic       evt;
  logic       win_last;
  logic [7:0] acc_next;
  logic [7:0] peak_next;
  logic [3:0] run_inc;

  // Sign-magnitude to two's complement; 8'h80 maps to zero like 8'h00.
  function automatic logic signed [7:0] sm_to_s(input logic [7:0] x);
    logic signed [7:0] m;
    m = signed'({1'b0, x[6:0]});
    return x[7] ? -m : m;
  endfunction

  assign evt      = bus.spike & ~spike_d & bus.en;
  assign win_last = (win_cnt == WIN_W'(WINDOW - 1));

  always_comb begin
    acc_next  = (evt && acc != 8'hFF) ? acc + 8'd1 : acc;
    peak_next = (sm_to_s(bus.v_in) > sm_to_s(peak_run)) ? bus.v_in : peak_run;
    run_inc   = (run == 4'd15) ? run : run + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spike_d    <= 1'b0;
      state      <= IDLE;
      isi_cnt    <= 16'd0;
      run        <= 4'd0;
      win_cnt    <= '0;
      acc        <= 8'd0;
      peak_run   <= 8'hFF;
      bus.isi        <= 16'd0;
      bus.isi_valid  <= 1'b0;
      bus.rate       <= 8'd0;
      bus.rate_valid <= 1'b0;
      bus.v_peak     <= 8'h00;
      bus.burst      <= 1'b0;
    end else begin
      spike_d        <= bus.spike;
      bus.isi_valid  <= 1'b0;
      bus.rate_valid <= 1'b0;

      // A long silence ends the burst without waiting for the next spike.
      if (state == ARMED && !evt && isi_cnt > ISI_LIM) begin
        run       <= 4'd0;
        bus.burst <= 1'b0;
      end

      if (bus.en) begin
        case (state)
          IDLE: begin
            if (evt) begin
              state   <= ARMED;
              isi_cnt <= 16'd1;
            end
          end
          ARMED: begin
            if (evt) begin
              bus.isi       <= isi_cnt;
              bus.isi_valid <= 1'b1;
              isi_cnt       <= 16'd1;
              if (isi_cnt <= ISI_LIM) begin
                run       <= run_inc;
                bus.burst <= (run_inc >= RUN_LIM);
              end else begin
                run       <= 4'd0;
                bus.burst <= 1'b0;
              end
            end else if (isi_cnt != 16'hFFFF) begin
              isi_cnt <= isi_cnt + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase

        // The closing cycle's own event and sample belong to the closing window.
        if (win_last) begin
          win_cnt        <= '0;
          bus.rate       <= acc_next;
          bus.v_peak     <= peak_next;
          bus.rate_valid <= 1'b1;
          acc            <= 8'd0;
          peak_run       <= 8'hFF;
        end else begin
          win_cnt  <= win_cnt + 1'b1;
          acc      <= acc_next;
          peak_run <= peak_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_izh_spike_analyzer.sv
// Directed bench for izh_spike_analyzer: a WINDOW=16 instance for ISI, burst and
// window edges, and a WINDOW=4096 instance for rate saturation.
module tb_izh_spike_analyzer;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  izh_spike_analyzer_if ia ();
  izh_spike_analyzer_if ib ();

  assign ib.en    = ia.en;
  assign ib.spike = ia.spike;
  assign ib.v_in  = ia.v_in;

  izh_spike_analyzer #(.WINDOW(16), .BURST_ISI(64), .BURST_MIN(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  izh_spike_analyzer #(.WINDOW(4096), .BURST_ISI(64), .BURST_MIN(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic s, input logic [7:0] v);
    ia.en    = e;
    ia.spike = s;
    ia.v_in  = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " isi"},        32'(ia.isi),        32'h0);
    checkOutput({tag, " isi_valid"},  32'(ia.isi_valid),  32'h0);
    checkOutput({tag, " rate"},       32'(ia.rate),       32'h0);
    checkOutput({tag, " rate_valid"}, 32'(ia.rate_valid), 32'h0);
    checkOutput({tag, " v_peak"},     32'(ia.v_peak),     32'h0);
    checkOutput({tag, " burst"},      32'(ia.burst),      32'h0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         nvalid;
    int         nburst;
    logic [7:0] v;
    logic       s;
    logic       e;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    #2;
    rst = 1'b0;
    #2;
    checkReset("reset");
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] window with no spikes, signed peak tracking");
    nvalid = 0;
    nburst = 0;
    for (int c = 1; c <= 48; c++) begin
      int w;
      int i;
      w = (c - 1) / 16;
      i = (c - 1) % 16;
      if (w == 0)      v = 8'h80 | 8'(i + 5);
      else if (w == 1) v = (i == 3) ? 8'h3A : (i == 7) ? 8'h45 : 8'hC0;
      else             v = (i == 9) ? 8'hFF : (i == 4) ? 8'h00 : 8'h80;
      applyStimulus(1'b1, 1'b0, v);
      tick();
      nvalid += int'(ia.isi_valid);
      nburst += int'(ia.burst);
      if (c == 15) checkOutput("w0 not yet closed", 32'(ia.rate_valid), 32'h0);
      if (c == 16) begin
        checkOutput("w0 rate_valid", 32'(ia.rate_valid), 32'h1);
        checkOutput("w0 rate", 32'(ia.rate), 32'h0);
        checkOutput("w0 v_peak all negative", 32'(ia.v_peak), 32'h85);
      end
      if (c == 17) checkOutput("rate_valid one cycle", 32'(ia.rate_valid), 32'h0);
      if (c == 32) checkOutput("w1 v_peak positive", 32'(ia.v_peak), 32'h45);
      if (c == 48) checkOutput("w2 v_peak negative zero", 32'(ia.v_peak), 32'h80);
    end
    checkOutput("no isi without spikes", 32'(nvalid), 32'h0);
    checkOutput("no burst without spikes", 32'(nburst), 32'h0);

    $display("[TB] ISI at spikes 10, 30, 80");
    doReset();
    for (int c = 1; c <= 100; c++) begin
      s = (c == 10 || c == 11 || c == 30 || c == 31 || c == 80 || c == 81);
      applyStimulus(1'b1, s, 8'h00);
      tick();
      if (c == 10) checkOutput("first spike no isi", 32'(ia.isi_valid), 32'h0);
      if (c == 11) checkOutput("held spike no isi", 32'(ia.isi_valid), 32'h0);
      if (c == 30) begin
        checkOutput("isi1 valid", 32'(ia.isi_valid), 32'h1);
        checkOutput("isi1 value", 32'(ia.isi), 32'd20);
      end
      if (c == 31) checkOutput("isi_valid one cycle", 32'(ia.isi_valid), 32'h0);
      if (c == 80) begin
        checkOutput("isi2 valid", 32'(ia.isi_valid), 32'h1);
        checkOutput("isi2 value", 32'(ia.isi), 32'd50);
        checkOutput("two short isi give burst", 32'(ia.burst), 32'h1);
      end
    end

    $display("[TB] burst onset and timeout");
    doReset();
    for (int c = 1; c <= 110; c++) begin
      s = (c == 10 || c == 20 || c == 30 || c == 40);
      applyStimulus(1'b1, s, 8'h00);
      tick();
      if (c == 16)  checkOutput("burst w0 rate", 32'(ia.rate), 32'd1);
      if (c == 20)  checkOutput("burst after isi1", 32'(ia.burst), 32'h0);
      if (c == 29)  checkOutput("burst before isi2", 32'(ia.burst), 32'h0);
      if (c == 30)  checkOutput("burst rises isi2", 32'(ia.burst), 32'h1);
      if (c == 32)  checkOutput("burst w1 rate", 32'(ia.rate), 32'd2);
      if (c == 40) begin
        checkOutput("burst held isi3", 32'(ia.burst), 32'h1);
        checkOutput("burst isi3 value", 32'(ia.isi), 32'd10);
      end
      if (c == 48)  checkOutput("burst w2 rate", 32'(ia.rate), 32'd1);
      if (c == 104) checkOutput("burst before timeout", 32'(ia.burst), 32'h1);
      if (c == 105) checkOutput("burst timeout", 32'(ia.burst), 32'h0);
    end

    $display("[TB] spike on final window cycle");
    doReset();
    for (int c = 1; c <= 32; c++) begin
      s = (c == 16 || c == 17);
      applyStimulus(1'b1, s, 8'h00);
      tick();
      if (c == 16) begin
        checkOutput("last cycle spike rate", 32'(ia.rate), 32'd1);
        checkOutput("last cycle rate_valid", 32'(ia.rate_valid), 32'h1);
      end
      if (c == 32) checkOutput("next window rate", 32'(ia.rate), 32'd0);
    end

    $display("[TB] enable gating and mid-ISI reset");
    doReset();
    for (int c = 1; c <= 160; c++) begin
      e = !(c >= 21 && c <= 120);
      s = (c == 5 || c == 50 || c == 51 || c == 70 || c == 145);
      applyStimulus(e, s, 8'h00);
      tick();
      if (c == 50)  checkOutput("disabled spike ignored a", 32'(ia.isi_valid), 32'h0);
      if (c == 70)  checkOutput("disabled spike ignored b", 32'(ia.isi_valid), 32'h0);
      if (c == 131) checkOutput("window held while disabled", 32'(ia.rate_valid), 32'h0);
      if (c == 132) checkOutput("window closes after resume", 32'(ia.rate_valid), 32'h1);
      if (c == 145) begin
        checkOutput("gated isi valid", 32'(ia.isi_valid), 32'h1);
        checkOutput("gated isi value", 32'(ia.isi), 32'd40);
      end
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    checkReset("mid-isi reset");
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      s = (c == 3 || c == 13);
      applyStimulus(1'b1, s, 8'h00);
      tick();
      if (c == 3) checkOutput("idle after reset", 32'(ia.isi_valid), 32'h0);
      if (c == 13) begin
        checkOutput("post reset isi valid", 32'(ia.isi_valid), 32'h1);
        checkOutput("post reset isi value", 32'(ia.isi), 32'd10);
      end
    end

    $display("[TB] rate saturation in a 4096-cycle window");
    doReset();
    for (int c = 1; c <= 8200; c++) begin
      s = (c <= 600 && (c % 2) == 1) || (c == 4100);
      applyStimulus(1'b1, s, 8'h00);
      tick();
      if (c == 16)   checkOutput("short window 8 spikes", 32'(ia.rate), 32'd8);
      if (c == 4095) checkOutput("long window still open", 32'(ib.rate_valid), 32'h0);
      if (c == 4096) begin
        checkOutput("saturated rate_valid", 32'(ib.rate_valid), 32'h1);
        checkOutput("saturated rate", 32'(ib.rate), 32'hFF);
        checkOutput("long window v_peak", 32'(ib.v_peak), 32'h00);
      end
      if (c == 8192) begin
        checkOutput("next long window valid", 32'(ib.rate_valid), 32'h1);
        checkOutput("next long window rate", 32'(ib.rate), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
